// File: rtl/clkdiv_prog_if.sv
// Divide-select handshake bundle between a requester and clkdiv_prog.
// master: drives div_i / div_valid_i and observes div_ready_o.
// slave : the divider, which accepts div_i when div_valid_i && div_ready_o.
interface clkdiv_prog_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] div_i;
  logic             div_valid_i;
  logic             div_ready_o;

  modport master (
    output div_i,
    output div_valid_i,
    input  div_ready_o
  );

  modport slave (
    input  div_i,
    input  div_valid_i,
    output div_ready_o
  );
endinterface

// File: rtl/clkdiv_prog.sv
// Programmable 50%-duty clock divider: clk_o period = 2*(D+1) clk_i cycles, D from a valid/ready port.
// Latency: first clk_o rise D+1 edges after the IDLE->RUN edge; a new D takes effect after the next high->low boundary.
// Backpressure: one pending select is held; div_ready_o stays low until it is applied, so a second offer waits.
// Ports: clk_i/rst_ni (sync active-low), en_i run request, div_if (div_i/div_valid_i/div_ready_o),
//        clk_o divided clock (flop output), tick_o one-cycle pulse on each clk_o rise, running_o high in RUN.
module clkdiv_prog #(
  parameter int WIDTH       = 4,
  parameter int DEFAULT_DIV = 0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  clkdiv_prog_if.slave div_if,
  output logic         clk_o,
  output logic         tick_o,
  output logic         running_o
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] pend_val;
  logic             pend_q;
  logic             phase_end;
  logic             xfer;

  // cnt never exceeds div_q, so cnt+1 cannot wrap even at D = 2^WIDTH-1.
  assign phase_end          = (cnt == div_q);
  assign xfer               = div_if.div_valid_i & ~pend_q;
  assign div_if.div_ready_o = ~pend_q;
  assign running_o          = (state == RUN);

  // A transfer needs pend_q=0 while applying needs pend_q=1, so a value
  // captured at a boundary edge is naturally deferred to the next boundary.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= IDLE;
      cnt      <= '0;
      clk_o    <= 1'b0;
      tick_o   <= 1'b0;
      div_q    <= DIV_RST;
      pend_q   <= 1'b0;
      pend_val <= '0;
    end else begin
      tick_o <= 1'b0;

      if (xfer) begin
        pend_q   <= 1'b1;
        pend_val <= div_if.div_i;
      end

      case (state)
        IDLE: begin
          cnt   <= '0;
          clk_o <= 1'b0;
          if (pend_q) begin
            div_q  <= pend_val;
            pend_q <= 1'b0;
          end
          if (en_i) begin
            state <= RUN;
          end
        end

        RUN: begin
          if (phase_end) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + WIDTH'(1);
          end

          if (!clk_o) begin
            // Low phase: a stop request truncates it immediately, no high pulse.
            if (!en_i) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (phase_end) begin
              clk_o  <= 1'b1;
              tick_o <= 1'b1;
            end
          end else if (phase_end) begin
            // High->low boundary: the only point where D changes or RUN ends,
            // so a high phase is never cut short.
            clk_o <= 1'b0;
            if (pend_q) begin
              div_q  <= pend_val;
              pend_q <= 1'b0;
            end
            if (!en_i) begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/clkdiv_prog.md
CLKDIV_PROG -- requirements
Module: clkdiv_prog

Interface
REQ-001 SHALL provide parameter: WIDTH, 4, width of the divide-select field.
REQ-002 SHALL provide parameter: DEFAULT_DIV, 0, divide select loaded at reset (0 = divide-by-2).
REQ-003 SHALL provide port: clk_i  input  1  source clock; all state updates on its rising edge.
REQ-004 SHALL provide port: rst_ni  input  1  synchronous, active-low reset.
REQ-005 SHALL provide port: en_i  input  1  run request for the divided clock.
REQ-006 SHALL provide port: div_i  input  WIDTH  requested divide select D; output period = 2*(D+1) clk_i cycles.
REQ-007 SHALL provide port: div_valid_i  input  1  div_i valid (valid/ready handshake).
REQ-008 SHALL provide port: div_ready_o  output  1  new divide select can be accepted.
REQ-009 SHALL provide port: clk_o  output  1  divided clock, driven directly from a flop, 50% duty.
REQ-010 SHALL provide port: tick_o  output  1  registered one-cycle pulse, high in the first clk_i cycle of each clk_o high phase.
REQ-011 SHALL provide port: running_o  output  1  high while FSM is in RUN.

Function
REQ-012 SHALL implement FSM states IDLE and RUN, plus half-period counter cnt (WIDTH bits), active select div_q, pending flag pend_q with pending value.
REQ-013 SHALL, in IDLE, hold clk_o=0, cnt=0, tick_o=0.
REQ-014 SHALL go IDLE->RUN at the edge sampling en_i=1, cnt<=0, clk_o remaining 0.
REQ-015 SHALL, in RUN, at each edge: if cnt==div_q then cnt<=0 and clk_o toggles, else cnt<=cnt+1; each phase thus lasts div_q+1 cycles.
REQ-016 SHALL make the first clk_o rising edge occur at the (div_q+1)th edge after the IDLE->RUN edge.
REQ-017 SHALL assert tick_o in exactly the cycles where clk_o has just gone 0->1; never in IDLE.
REQ-018 SHALL, when en_i=0 is sampled in RUN with clk_o=0, go IDLE at that edge (low phase truncated, no high pulse emitted).
REQ-019 SHALL, when en_i=0 is sampled in RUN with clk_o=1, complete the full high phase, then go IDLE at the high->low edge; en_i reasserting meanwhile cancels the stop.
REQ-020 SHALL never produce a clk_o high phase shorter than div_q+1 cycles outside reset.
REQ-021 SHALL define div_ready_o = ~pend_q; a transfer occurs when div_valid_i && div_ready_o at an edge, setting pend_q and capturing div_i.
REQ-022 SHALL apply a pending value (div_q<=pending, pend_q<=0) only at a high->low clk_o edge (boundary) in RUN, or at the next edge when in IDLE.
REQ-023 SHALL, for a transfer at the same edge as a boundary, not apply it at that boundary but at the following one.
REQ-024 SHALL apply the new div_q starting with the low phase following the boundary; the phase in progress uses the old div_q.
REQ-025 SHALL hold div_valid_i with div_ready_o=0 without loss; values offered while not ready are not captured.
REQ-026 SHALL treat D=2^WIDTH-1 as the maximum (period 2^(WIDTH+1)); no overflow of cnt.

Reset
REQ-027 SHALL, at an edge with rst_ni=0: state=IDLE, clk_o=0, cnt=0, tick_o=0, running_o=0, pend_q=0 (div_ready_o=1), div_q=DEFAULT_DIV.
REQ-028 SHALL apply reset mid-operation regardless of phase; a truncated high phase is permitted only under reset.
REQ-029 SHALL ignore en_i and div_valid_i during reset.

Verification
REQ-030 SHALL check: reset, DEFAULT_DIV=0, en_i=1 -> clk_o rises 1 edge after enable, toggles every cycle (period 2), tick_o every 2nd cycle, running_o=1.
REQ-031 SHALL check: running at D=0, transfer div_i=2 -> div_ready_o=0 until next high->low edge, then period 6 (3 high/3 low), no runt phase.
REQ-032 SHALL check: D=3, en_i dropped 1 cycle after clk_o rises -> high phase lasts full 4 cycles, clk_o=0 and running_o=0 at the following edge.
REQ-033 SHALL check: D=3, en_i dropped during low phase -> IDLE at that edge, clk_o stays 0, tick_o never pulses.
REQ-034 SHALL check: rst_ni=0 for 1 cycle while clk_o=1 with a pending value -> clk_o=0, div_q=DEFAULT_DIV, div_ready_o=1, pending discarded.
REQ-035 SHALL check: in IDLE, transfer div_i=15 -> div_ready_o back to 1 within 2 cycles; then en_i=1 -> period 32, tick_o every 32 cycles.
